// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front-end: forwarding-select encodings,
// PC sequencer state type and the default reset fetch address.
package mips_pkg;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   typedef enum logic {
      ST_WAIT  = 1'b0,
      ST_FETCH = 1'b1
   } pc_seq_state_t;

endpackage

// File: rtl/jr_fwd_unit.sv
// Combinational jr operand logic: load-use hazard detect and forwarding
// source select for the jr register operand.
module jr_fwd_unit
   import mips_pkg::*;
(
   input  logic       i_redirect_jr,
   input  logic [4:0] i_jr_rs,
   input  logic       i_ex_wr_en,
   input  logic       i_ex_is_load,
   input  logic [4:0] i_ex_wr_addr,
   input  logic       i_mem_wr_en,
   input  logic [4:0] i_mem_wr_addr,
   output logic       o_hz,
   output logic [1:0] o_fwd_sel
);

   logic w_rs_nz;
   logic w_ex_match;
   logic w_mem_match;

   assign w_rs_nz     = (i_jr_rs != 5'd0);
   assign w_ex_match  = w_rs_nz & i_ex_wr_en & (i_ex_wr_addr == i_jr_rs);
   assign w_mem_match = w_rs_nz & i_mem_wr_en & (i_mem_wr_addr == i_jr_rs);

   // A load in EX has no result yet, so the jr must wait one cycle.
   assign o_hz = i_redirect_jr & w_ex_match & i_ex_is_load;

   always_comb begin
      o_fwd_sel = FWD_RF;
      if (w_ex_match && !i_ex_is_load) begin
         o_fwd_sel = FWD_EX;
      end else if (w_mem_match) begin
         o_fwd_sel = FWD_MEM;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer for the MIPS front-end.
// MIPS_DELAY_SLOT_EN: when defined, the post-branch instruction executes and ifid_flush stays 0.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC          = DEFAULT_RESET_PC,
   parameter int          RESET_WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] npc,
   input  logic        redirect_jr,
   input  logic        redirect_j,
   input  logic        redirect_br,
   input  logic [4:0]  jr_rs,
   input  logic        ex_wr_en,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_wr_addr,
   input  logic        mem_wr_en,
   input  logic [4:0]  mem_wr_addr,
   input  logic        imem_ready,
   input  logic        ext_stall,
   output logic [31:0] pc,
   output logic        imem_req,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic [1:0]  fwd_sel
);

   localparam int CNT_W = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESET_WAIT_CYCLES - 1);

   pc_seq_state_t   r_state, w_state_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic [31:0]     r_pc, w_pc_next;
   logic            w_hz;
   logic            w_fire;
   logic            w_redirect;
   logic [1:0]      w_fwd_sel;

   jr_fwd_unit u_jr_fwd (
      .i_redirect_jr (redirect_jr),
      .i_jr_rs       (jr_rs),
      .i_ex_wr_en    (ex_wr_en),
      .i_ex_is_load  (ex_is_load),
      .i_ex_wr_addr  (ex_wr_addr),
      .i_mem_wr_en   (mem_wr_en),
      .i_mem_wr_addr (mem_wr_addr),
      .o_hz          (w_hz),
      .o_fwd_sel     (w_fwd_sel)
   );

   // The jr > j > br priority is already folded into npc upstream; any redirect takes it.
   assign w_redirect = redirect_jr | redirect_j | redirect_br;
   assign pc         = r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_WAIT;
         r_cnt   <= CNT_INIT;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_pc    <= w_pc_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_pc_next    = r_pc;
      w_fire       = 1'b0;
      imem_req     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      fwd_sel      = FWD_RF;
      case (r_state)
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_state_next = ST_FETCH;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         ST_FETCH: begin
            imem_req    = 1'b1;
            fwd_sel     = w_fwd_sel;
            w_fire      = imem_ready & ~w_hz & ~ext_stall;
            ifid_write  = w_fire;
            idex_bubble = ~ext_stall & ~w_fire;
`ifdef MIPS_DELAY_SLOT_EN
            ifid_flush  = 1'b0;
`else
            ifid_flush  = w_fire & w_redirect;
`endif
            if (w_fire) begin
               w_pc_next = w_redirect ? (npc & 32'hFFFF_FFFC) : (r_pc + 32'd4);
            end
         end
         default: begin
            w_state_next = ST_WAIT;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] npc;
   logic        redirect_jr, redirect_j, redirect_br;
   logic [4:0]  jr_rs;
   logic        ex_wr_en, ex_is_load;
   logic [4:0]  ex_wr_addr;
   logic        mem_wr_en;
   logic [4:0]  mem_wr_addr;
   logic        imem_ready, ext_stall;
   logic [31:0] pc;
   logic        imem_req, ifid_write, ifid_flush, idex_bubble;
   logic [1:0]  fwd_sel;

   int checks   = 0;
   int failures = 0;

`ifdef MIPS_DELAY_SLOT_EN
   localparam logic EXP_FLUSH = 1'b0;
`else
   localparam logic EXP_FLUSH = 1'b1;
`endif

   pc_sequencer #(
      .RESET_PC          (32'h0000_3000),
      .RESET_WAIT_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .npc         (npc),
      .redirect_jr (redirect_jr),
      .redirect_j  (redirect_j),
      .redirect_br (redirect_br),
      .jr_rs       (jr_rs),
      .ex_wr_en    (ex_wr_en),
      .ex_is_load  (ex_is_load),
      .ex_wr_addr  (ex_wr_addr),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .imem_ready  (imem_ready),
      .ext_stall   (ext_stall),
      .pc          (pc),
      .imem_req    (imem_req),
      .ifid_write  (ifid_write),
      .ifid_flush  (ifid_flush),
      .idex_bubble (idex_bubble),
      .fwd_sel     (fwd_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      $display("check %s observed=%h expected=%h", tag, obs, exp);
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; npc = '0;
      redirect_jr = 1'b0; redirect_j = 1'b0; redirect_br = 1'b0;
      jr_rs = '0; ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_addr = '0;
      mem_wr_en = 1'b0; mem_wr_addr = '0; imem_ready = 1'b1; ext_stall = 1'b0;

      repeat (3) tick();
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_req", imem_req, 0);
      chk("rst_write", ifid_write, 0);
      chk("rst_bubble", idex_bubble, 0);

      rst_n = 1'b1; #1;
      chk("wait0_req", imem_req, 0);
      tick();
      chk("wait1_req", imem_req, 0);
      tick();
      chk("fetch_req", imem_req, 1);
      chk("fetch_pc0", pc, 32'h0000_3000);
      chk("fetch_write", ifid_write, 1);
      tick();
      chk("seq_pc1", pc, 32'h0000_3004);
      tick();
      chk("seq_pc2", pc, 32'h0000_3008);

      redirect_j = 1'b1; npc = 32'h0040_0010; #1;
      chk("j_flush", ifid_flush, EXP_FLUSH);
      chk("j_write", ifid_write, 1);
      tick();
      chk("j_pc", pc, 32'h0040_0010);
      redirect_j = 1'b0; #1;
      chk("j_flush_clr", ifid_flush, 0);
      tick();
      chk("seq_after_j", pc, 32'h0040_0014);

      // jr $5 while EX holds lw $5
      redirect_jr = 1'b1; jr_rs = 5'd5; npc = 32'h0000_1234;
      ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd5; #1;
      chk("hz_bubble", idex_bubble, 1);
      chk("hz_write", ifid_write, 0);
      chk("hz_flush", ifid_flush, 0);
      tick();
      chk("hz_pc_hold", pc, 32'h0040_0014);
      ex_wr_en = 1'b0; ex_is_load = 1'b0; mem_wr_en = 1'b1; mem_wr_addr = 5'd5; #1;
      chk("hz2_fwd", fwd_sel, 2);
      chk("hz2_bubble", idex_bubble, 0);
      chk("hz2_write", ifid_write, 1);
      chk("hz2_flush", ifid_flush, EXP_FLUSH);
      tick();
      chk("jr_pc", pc, 32'h0000_1234);

      // jr $5 with addu $5 in EX (and $5 also in MEM): EX wins
      ex_wr_en = 1'b1; ex_is_load = 1'b0; ex_wr_addr = 5'd5; npc = 32'h0000_2000; #1;
      chk("ex_fwd", fwd_sel, 1);
      chk("ex_bubble", idex_bubble, 0);
      tick();
      chk("ex_pc", pc, 32'h0000_2000);

      // jr $0: never a hazard, never forwarded
      jr_rs = 5'd0; ex_wr_addr = 5'd0; ex_is_load = 1'b1; mem_wr_addr = 5'd0;
      npc = 32'h0000_2103; #1;
      chk("r0_fwd", fwd_sel, 0);
      chk("r0_bubble", idex_bubble, 0);
      chk("r0_write", ifid_write, 1);
      tick();
      chk("r0_pc_align", pc, 32'h0000_2100);

      redirect_jr = 1'b0; ex_wr_en = 1'b0; ex_is_load = 1'b0; mem_wr_en = 1'b0;
      redirect_br = 1'b1; npc = 32'h0000_5550; imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("br_wait_bubble", idex_bubble, 1);
         chk("br_wait_write", ifid_write, 0);
         chk("br_wait_flush", ifid_flush, 0);
         tick();
         chk("br_wait_pc", pc, 32'h0000_2100);
      end
      imem_ready = 1'b1; #1;
      chk("br_write", ifid_write, 1);
      chk("br_flush", ifid_flush, EXP_FLUSH);
      tick();
      chk("br_pc", pc, 32'h0000_5550);

      redirect_br = 1'b0; ext_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("stall_bubble", idex_bubble, 0);
         chk("stall_write", ifid_write, 0);
         chk("stall_flush", ifid_flush, 0);
         tick();
         chk("stall_pc", pc, 32'h0000_5550);
      end
      ext_stall = 1'b0; #1;
      chk("unstall_write", ifid_write, 1);
      tick();
      chk("unstall_pc", pc, 32'h0000_5554);

      redirect_j = 1'b1; npc = 32'hFFFF_FFFF;
      tick();
      chk("top_pc", pc, 32'hFFFF_FFFC);
      redirect_j = 1'b0;
      tick();
      chk("wrap_pc", pc, 32'h0000_0000);

      rst_n = 1'b0; #1;
      chk("async_rst_pc", pc, 32'h0000_3000);
      chk("async_rst_req", imem_req, 0);
      chk("async_rst_write", ifid_write, 0);
      tick();
      rst_n = 1'b1; #1;
      chk("rerel_req0", imem_req, 0);
      tick();
      chk("rerel_req1", imem_req, 0);
      tick();
      chk("rerel_req2", imem_req, 1);
      chk("rerel_pc", pc, 32'h0000_3000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Front-end controller that owns the program counter and sequences the next-PC calculation stage of the MIPS pipeline. Each cycle it decides whether the PC advances to PC+4, is redirected to the computed target (jr/j/taken branch), or holds. Holds come from instruction-memory wait, a jr-after-load hazard, or a downstream stall. It also drives the IF/ID write/flush, ID/EX bubble and jr operand-forwarding selects.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- RESET_WAIT_CYCLES, 2, idle cycles after reset release before the first fetch (≥1)

Ports: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- npc  in  32  target from the next-PC calculation stage
- redirect_jr / redirect_j / redirect_br  in  1 each  ID-stage jr, j, taken branch
- jr_rs  in  5  rs field of the jr in ID
- ex_wr_en, ex_is_load  in  1  EX-stage writeback enable, EX is a load
- ex_wr_addr  in  5  EX destination register
- mem_wr_en  in  1  MEM-stage writeback enable
- mem_wr_addr  in  5  MEM destination register
- imem_ready  in  1  instruction memory accepts/returns the fetch this cycle
- ext_stall  in  1  downstream freeze of the whole pipeline
- pc  out  32  current fetch address, registered
- imem_req  out  1  fetch request
- ifid_write  out  1  IF/ID register load enable
- ifid_flush  out  1  squash IF/ID contents
- idex_bubble  out  1  insert a NOP into ID/EX
- fwd_sel  out  2  jr operand source: 0 = register file, 1 = EX result, 2 = MEM result

## Operation
- States: WAIT (post-reset count), FETCH.
- Reset: pc=RESET_PC, state=WAIT, counter=RESET_WAIT_CYCLES-1. All outputs 0 while in WAIT.
- WAIT: counter decrements each cycle; go to FETCH when counter==0.
- FETCH: imem_req=1.
- Hazard: hz = redirect_jr & ex_wr_en & ex_is_load & (ex_wr_addr==jr_rs) & (jr_rs!=0).
- Fire: fire = imem_ready & !hz & !ext_stall. ifid_write = fire.
- PC update on fire: if any redirect, pc ← {npc[31:2],2'b00}; else pc ← pc+4, modulo 2^32.
- Redirect priority: jr > j > br. npc is already resolved by the next-PC calculation stage; this block only qualifies it.
- idex_bubble = (state==FETCH) & !ext_stall & !fire.
- ext_stall: freezes everything. No pc change, no bubble, no flush.
- fwd_sel (combinational, jr_rs!=0 required, else 0):
  - 1 if ex_wr_en & !ex_is_load & ex_wr_addr==jr_rs
  - else 2 if mem_wr_en & mem_wr_addr==jr_rs
  - else 0
- Boundary cases:
  - Redirect with imem not ready: no action, re-evaluated next cycle.
  - Hazard clears naturally one cycle later, because the bubble occupies EX and the load is in MEM, so fwd_sel=2.
  - pc 32'hFFFF_FFFC + 4 wraps to 0.
  - Reset asserted mid-operation returns to WAIT immediately and asynchronously.

## Timing
- pc updates on the clk edge after a fire cycle. Redirect-to-target latency is 1 cycle.
- ifid_write, idex_bubble, ifid_flush and fwd_sel are combinational from the current state and inputs.
- jr after load: exactly 1 bubble cycle, then the jr fires with fwd_sel=2.
- First imem_req occurs RESET_WAIT_CYCLES cycles after rst_n deasserts.

## Configuration
- MIPS_DELAY_SLOT_EN defined:
  - The instruction fetched after a control transfer executes.
  - ifid_flush is tied to 0.
- MIPS_DELAY_SLOT_EN undefined:
  - ifid_flush = fire & (redirect_jr | redirect_j | redirect_br), squashing the wrong-path instruction.

## Structure
- Shared package mips_pkg:
  - FWD_RF/FWD_EX/FWD_MEM encodings
  - pc_seq_state_t enum
  - default RESET_PC constant
- One sub-module, jr_fwd_unit: combinational hz and fwd_sel generation.
- FSM, counter and PC register stay in pc_sequencer.

## Test plan
- Reset release, RESET_WAIT_CYCLES=2, imem_ready=1 -> imem_req rises on cycle 2 with pc=0x3000, then 0x3004, 0x3008 on successive cycles.
- redirect_j, npc=0x0040_0010, imem_ready=1 -> next pc=0x0040_0010. ifid_flush=1 for one cycle without the macro, 0 with it.
- jr $5 in ID, EX is lw to $5 -> one cycle with idex_bubble=1, ifid_write=0, pc held. Next cycle fwd_sel=2, fire, pc=npc.
- jr $5 with EX addu to $5 -> fwd_sel=1, no bubble. jr $0 with EX writing $0 -> fwd_sel=0, no bubble.
- imem_ready low 3 cycles during redirect_br -> pc held, 3 bubbles. Redirect taken on the ready cycle. ext_stall held -> no bubble, no pc change.
- pc=0xFFFF_FFFC sequential fetch -> pc=0. rst_n pulsed low mid-run -> pc=0x3000 immediately and state returns to WAIT.
